servo_lock_ctrl: RTL and testbench

Parametrised servo actuator controller for the digital locker. On a validated-password level (`pw_true`) it drives the servo command angle from the closed to the open position, holds it open for a programmable time, then returns it to closed. It supports an optional slew-rate ramp, hold retrigger and a priority force-close. Its output feeds the PWM servo driver's angle input.

---
 rtl/servo_pkg.sv | 16 +
 rtl/servo_ramp.sv | 69 ++++++
 rtl/servo_lock_ctrl.sv | 106 ++++++++++
 tb/tb_servo_lock_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared state type and default constants for the servo lock controller.
package servo_pkg;

  typedef enum logic [1:0] {
    StClosed,
    StOpening,
    StHold,
    StClosing
  } servo_state_e;

  localparam int unsigned SERVO_OPEN_DEF   = 40;
  localparam int unsigned SERVO_CLOSED_DEF = 90;
  localparam int unsigned SERVO_ANGLE_W    = 8;
  localparam int unsigned SERVO_CNT_W      = 28;

endpackage

// File: rtl/servo_ramp.sv
// Servo angle register with optional 1-degree-per-step slew toward a target.
// SERVO_LOCK_SLEW_EN selects the ramp; otherwise the angle jumps on sync_i.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int unsigned ANGLE_W      = SERVO_ANGLE_W,
  parameter int unsigned CLOSED_ANGLE = SERVO_CLOSED_DEF,
  parameter int unsigned STEP_CYCLES  = 120000,
  parameter int unsigned CNT_W        = SERVO_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ANGLE_W-1:0] target_i,
  input  logic               en_i,
  input  logic               sync_i,
  output logic [ANGLE_W-1:0] angle_o,
  output logic               at_target_o
);

  logic [ANGLE_W-1:0] angle_q, angle_d;

  assign angle_o     = angle_q;
  assign at_target_o = (angle_q == target_i);

  if (STEP_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("servo_ramp: STEP_CYCLES and CNT_W must be at least 1");
  end

`ifdef SERVO_LOCK_SLEW_EN
  logic [CNT_W-1:0] step_q, step_d;

  // A state change restarts the step timer so a reversal waits a full step.
  always_comb begin
    angle_d = angle_q;
    step_d  = '0;
    if (!sync_i && en_i && !at_target_o) begin
      if (step_q == CNT_W'(STEP_CYCLES - 1)) begin
        angle_d = (angle_q < target_i) ? angle_q + ANGLE_W'(1) : angle_q - ANGLE_W'(1);
      end else begin
        step_d = step_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end
`else
  always_comb begin
    angle_d = angle_q;
    if (sync_i || en_i) begin
      angle_d = target_i;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q <= ANGLE_W'(CLOSED_ANGLE);
    end else begin
      angle_q <= angle_d;
    end
  end

endmodule

// File: rtl/servo_lock_ctrl.sv
// Locker servo controller: open on pw_true, hold, then close; force_close wins.
// Define SERVO_LOCK_SLEW_EN to ramp the angle at STEP_CYCLES per degree.
module servo_lock_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned ANGLE_W      = SERVO_ANGLE_W,
  parameter int unsigned OPEN_ANGLE   = SERVO_OPEN_DEF,
  parameter int unsigned CLOSED_ANGLE = SERVO_CLOSED_DEF,
  parameter int unsigned HOLD_CYCLES  = 60000000,
  parameter int unsigned STEP_CYCLES  = 120000,
  parameter int unsigned CNT_W        = SERVO_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pw_true,
  input  logic               force_close,
  output logic [ANGLE_W-1:0] rotate_angle,
  output logic               is_open,
  output logic               busy
);

  localparam logic [ANGLE_W-1:0] OpenA    = ANGLE_W'(OPEN_ANGLE);
  localparam logic [ANGLE_W-1:0] ClosedA  = ANGLE_W'(CLOSED_ANGLE);
  localparam logic [CNT_W-1:0]   HoldLast = CNT_W'(HOLD_CYCLES - 1);

  if (OPEN_ANGLE == CLOSED_ANGLE || HOLD_CYCLES < 1) begin : g_bad_param
    $error("servo_lock_ctrl: angles must differ and HOLD_CYCLES must be at least 1");
  end

  servo_state_e       state_q, state_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               is_open_q, busy_q;
  logic [ANGLE_W-1:0] target;
  logic               at_target, open_req, hold_done;

  assign open_req  = pw_true && !force_close;
  assign hold_done = (hold_q == HoldLast) && !pw_true;

  // Target follows the direction the FSM is heading this cycle, independent of at_target.
  always_comb begin
    target = ClosedA;
    unique case (state_q)
      StClosed, StClosing: if (open_req) target = OpenA;
      StOpening:           if (!force_close) target = OpenA;
      StHold:              if (!force_close && !hold_done) target = OpenA;
      default:             target = ClosedA;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    unique case (state_q)
      StClosed: if (open_req) state_d = StOpening;
      StOpening: begin
        if (force_close)    state_d = StClosing;
        else if (at_target) state_d = StHold;
      end
      StHold: begin
        if (force_close || hold_done) begin
          state_d = StClosing;
        end else if (!pw_true) begin
          hold_d = (hold_q == '1) ? hold_q : hold_q + CNT_W'(1);
        end
      end
      StClosing: begin
        if (open_req)       state_d = StOpening;
        else if (at_target) state_d = StClosed;
      end
      default: state_d = StClosed;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClosed;
      hold_q    <= '0;
      is_open_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      is_open_q <= (state_d == StHold);
      busy_q    <= (state_d == StOpening) || (state_d == StClosing);
    end
  end

  servo_ramp #(
    .ANGLE_W      (ANGLE_W),
    .CLOSED_ANGLE (CLOSED_ANGLE),
    .STEP_CYCLES  (STEP_CYCLES),
    .CNT_W        (CNT_W)
  ) u_ramp (
    .clk         (clk),
    .rst_n       (rst_n),
    .target_i    (target),
    .en_i        ((state_q == StOpening) || (state_q == StClosing)),
    .sync_i      (state_d != state_q),
    .angle_o     (rotate_angle),
    .at_target_o (at_target)
  );

  assign is_open = is_open_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_servo_lock_ctrl.sv
// Directed bench for servo_lock_ctrl; covers both builds of SERVO_LOCK_SLEW_EN.
module tb_servo_lock_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pw_true;
  logic       force_close;
  logic [7:0] rotate_angle;
  logic       is_open;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  servo_lock_ctrl #(
    .ANGLE_W      (8),
    .OPEN_ANGLE   (40),
    .CLOSED_ANGLE (90),
    .HOLD_CYCLES  (100),
    .STEP_CYCLES  (4),
    .CNT_W        (28)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pw_true      (pw_true),
    .force_close  (force_close),
    .rotate_angle (rotate_angle),
    .is_open      (is_open),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ang, input bit op, input bit bz);
    chk({tag, ".angle"}, 32'(rotate_angle), 32'(ang));
    chk({tag, ".is_open"}, 32'(is_open), 32'(op));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    rst_n       = 1'b0;
    pw_true     = 1'b0;
    force_close = 1'b0;
    tick(3);
    chk_out("reset", 90, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle.angle", 32'(rotate_angle), 32'd90);
    end
    chk_out("idle_end", 90, 0, 0);

    // Both requests in CLOSED: force_close wins, nothing moves.
    pw_true = 1'b1;
    force_close = 1'b1;
    tick(3);
    chk_out("both_closed", 90, 0, 0);
    pw_true = 1'b0;
    force_close = 1'b0;
    tick(1);

`ifndef SERVO_LOCK_SLEW_EN
    // Jump open, hold 100 cycles, jump closed.
    pw_true = 1'b1;
    tick(1);
    chk_out("open_entry", 40, 0, 1);
    pw_true = 1'b0;
    tick(1);
    chk_out("hold_entry", 40, 1, 0);
    tick(99);
    chk_out("hold_last", 40, 1, 0);
    tick(1);
    chk_out("close_entry", 90, 0, 1);
    tick(1);
    chk_out("closed", 90, 0, 0);

    // Retrigger at hold count 80.
    pw_true = 1'b1;
    tick(1);
    pw_true = 1'b0;
    tick(81);
    pw_true = 1'b1;
    tick(1);
    pw_true = 1'b0;
    tick(99);
    chk_out("retrig_hold", 40, 1, 0);
    tick(1);
    chk_out("retrig_close", 90, 0, 1);
    tick(1);

    // force_close during HOLD, then reopen straight out of CLOSING.
    pw_true = 1'b1;
    tick(2);
    pw_true = 1'b0;
    tick(10);
    force_close = 1'b1;
    tick(1);
    chk_out("force_hold", 90, 0, 1);
    force_close = 1'b0;
    pw_true = 1'b1;
    tick(1);
    chk_out("reverse_open", 40, 0, 1);
    pw_true = 1'b0;
    tick(1);
    chk_out("reverse_hold", 40, 1, 0);

    // Asynchronous reset mid-HOLD.
    tick(5);
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid_hold", 90, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk_out("after_rst", 90, 0, 0);
`else
    // One-cycle request: full ramp, hold, ramp back.
    pw_true = 1'b1;
    tick(1);
    pw_true = 1'b0;
    chk_out("ramp_start", 90, 0, 1);
    tick(3);
    chk("ramp_e3", 32'(rotate_angle), 32'd90);
    tick(1);
    chk("ramp_e4", 32'(rotate_angle), 32'd89);
    tick(196);
    chk_out("ramp_e200", 40, 0, 1);
    tick(1);
    chk_out("hold_e201", 40, 1, 0);
    tick(99);
    chk_out("hold_e300", 40, 1, 0);
    tick(1);
    chk_out("close_e301", 40, 0, 1);
    tick(4);
    chk("close_e305", 32'(rotate_angle), 32'd41);
    tick(196);
    chk_out("close_e501", 90, 0, 1);
    tick(1);
    chk_out("closed_e502", 90, 0, 0);

    // Retrigger at hold count 80.
    pw_true = 1'b1;
    tick(1);
    pw_true = 1'b0;
    tick(201);
    chk_out("rt_hold", 40, 1, 0);
    tick(80);
    pw_true = 1'b1;
    tick(1);
    pw_true = 1'b0;
    tick(99);
    chk_out("rt_hold_end", 40, 1, 0);
    tick(1);
    chk_out("rt_close", 40, 0, 1);

    // Reverse at angle 70 while closing.
    tick(120);
    chk("rev_at70", 32'(rotate_angle), 32'd70);
    pw_true = 1'b1;
    tick(1);
    pw_true = 1'b0;
    chk_out("rev_entry", 70, 0, 1);
    tick(3);
    chk("rev_e3", 32'(rotate_angle), 32'd70);
    tick(1);
    chk("rev_e4", 32'(rotate_angle), 32'd69);
    tick(116);
    chk_out("rev_at40", 40, 0, 1);
    tick(1);
    chk_out("rev_hold", 40, 1, 0);

    // force_close during HOLD.
    tick(10);
    force_close = 1'b1;
    tick(1);
    chk_out("force_hold", 40, 0, 1);
    force_close = 1'b0;
    tick(4);
    chk("force_step", 32'(rotate_angle), 32'd41);

    // Asynchronous reset mid-ramp.
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid_ramp", 90, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk_out("after_rst", 90, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
